alu_issue: RTL and testbench

- Issue/decode stage that drives the ALU's `func`/`a`/`b`/`enable` interface and collects its registered `res`.
- Accepts one RV32I instruction plus its register operands over a valid/ready handshake.
- Decodes OP, OP-IMM, BRANCH, LUI and AUIPC into ALU operations and sequences the ALU's one-cycle registered latency.
- Presents writeback and branch results to the next stage over a second valid/ready handshake.

---
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_issue.sv | 120 ++++++++++++
 tb/tb_alu_issue.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream offer, ALU drive/result and writeback bundle for the issue stage
interface alu_issue_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic            alu_enable;
  logic [3:0]      alu_func;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic            out_we;
  logic [XLEN-1:0] out_value;
  logic            out_branch;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  modport master (
    input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, alu_res, out_ready,
    output in_ready, alu_enable, alu_func, alu_a, alu_b,
           out_valid, out_rd, out_we, out_value, out_branch, out_taken, out_target, out_illegal
  );
  modport slave (
    output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, alu_res, out_ready,
    input  in_ready, alu_enable, alu_func, alu_a, alu_b,
           out_valid, out_rd, out_we, out_value, out_branch, out_taken, out_target, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage sequencing a one-cycle registered ALU
module alu_issue (
  input logic       clock,
  input logic       reset,
  alu_issue_if.master bus
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_t;
  state_t      state;
  logic [31:0] ins, rs1, rs2, i_imm, u_imm, b_imm, dec_a, dec_b;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [3:0]  dec_func;
  logic        dec_ill, dec_br, shift;
  function automatic logic [3:0] arith(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    arith = alt ? 4'h8 : 4'h0;
      3'd1:    arith = 4'h6;
      3'd2:    arith = 4'h1;
      3'd3:    arith = 4'h2;
      3'd4:    arith = 4'h5;
      3'd5:    arith = alt ? 4'h9 : 4'h7;
      3'd6:    arith = 4'h4;
      default: arith = 4'h3;
    endcase
  endfunction
  assign ins          = bus.in_instr;
  assign rs1          = bus.in_rs1_val;
  assign rs2          = bus.in_rs2_val;
  assign f7           = ins[31:25];
  assign f3           = ins[14:12];
  assign shift        = f3[1:0] == 2'b01;
  assign i_imm        = {{20{ins[31]}}, ins[31:20]};
  assign u_imm        = {ins[31:12], 12'h000};
  assign b_imm        = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign bus.in_ready = state == IDLE;
  // decode the offered instruction into ALU func/operands and legality
  always_comb begin
    dec_func = 4'h0;
    dec_a    = rs1;
    dec_b    = rs2;
    dec_ill  = 1'b0;
    dec_br   = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        dec_func = arith(f3, f7[5]);
        dec_b    = shift ? {27'd0, rs2[4:0]} : rs2;
        dec_ill  = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0010011: begin
        dec_func = arith(f3, shift & f7[5]);
        dec_b    = shift ? {27'd0, ins[24:20]} : i_imm;
        dec_ill  = shift && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
      end
      7'b1100011: begin
        dec_br   = 1'b1;
        dec_func = f3 == 3'd0 ? 4'hA : f3 == 3'd1 ? 4'hB : f3 == 3'd4 ? 4'h1 :
                   f3 == 3'd5 ? 4'hC : f3 == 3'd6 ? 4'h2 : 4'hD;
        dec_ill  = f3[2:1] == 2'b01;
      end
      7'b0110111: begin
        dec_a = '0;
        dec_b = u_imm;
      end
      7'b0010111: begin
        dec_a = bus.in_pc;
        dec_b = u_imm;
      end
      default: dec_ill = 1'b1;
    endcase
  end
  // issue FSM: latch on accept, pulse the ALU, capture its result, hold until drained
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      bus.alu_enable  <= 1'b0;
      bus.alu_func    <= '0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_rd      <= '0;
      bus.out_we      <= 1'b0;
      bus.out_value   <= '0;
      bus.out_branch  <= 1'b0;
      bus.out_taken   <= 1'b0;
      bus.out_target  <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      bus.alu_enable <= state == IDLE && bus.in_valid && !dec_ill;
      case (state)
        IDLE: if (bus.in_valid) begin
          state           <= dec_ill ? DONE : EXEC;
          bus.out_valid   <= dec_ill;
          bus.out_rd      <= ins[11:7];
          bus.out_we      <= !dec_ill && !dec_br && ins[11:7] != 5'd0;
          bus.out_value   <= '0;
          bus.out_branch  <= dec_br && !dec_ill;
          bus.out_taken   <= 1'b0;
          bus.out_target  <= dec_br ? bus.in_pc + b_imm : '0;
          bus.out_illegal <= dec_ill;
          if (!dec_ill) begin
            bus.alu_func <= dec_func;
            bus.alu_a    <= dec_a;
            bus.alu_b    <= dec_b;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          state         <= DONE;
          bus.out_value <= bus.alu_res;
          bus.out_taken <= bus.out_branch && bus.alu_res[0];
          bus.out_valid <= 1'b1;
        end
        default: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized check of alu_issue against an instruction-level reference model
module tb_alu_issue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  alu_issue_if bus ();
  alu_issue dut (.clock(clock), .reset(reset), .bus(bus.master));
  always #5 clock = ~clock;
  typedef struct packed {
    logic        ill, br, we, taken;
    logic [4:0]  rd;
    logic [3:0]  func;
    logic [31:0] value, target, a, b;
  } exp_t;
  function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'h0: return a + b;
      4'h1: return {31'd0, $signed(a) < $signed(b)};
      4'h2: return {31'd0, a < b};
      4'h3: return a & b;
      4'h4: return a | b;
      4'h5: return a ^ b;
      4'h6: return a << b;
      4'h7: return a >> b;
      4'h8: return a - b;
      4'h9: return $signed(a) >>> b;
      4'hA: return {31'd0, a == b};
      4'hB: return {31'd0, a != b};
      4'hC: return {31'd0, $signed(a) >= $signed(b)};
      4'hD: return {31'd0, a >= b};
      default: return 32'd0;
    endcase
  endfunction
  // ALU stand-in with one-cycle registered result
  always @(posedge clock) if (bus.alu_enable) bus.alu_res <= alu_model(bus.alu_func, bus.alu_a, bus.alu_b);
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] ii, ui, bi;
    logic [4:0] sh, si;
    e  = '0;
    f7 = ins[31:25];
    f3 = ins[14:12];
    sh = r2[4:0];
    si = ins[24:20];
    ii = {{20{ins[31]}}, ins[31:20]};
    ui = {ins[31:12], 12'h000};
    bi = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    e.rd = ins[11:7];
    e.a  = r1;
    e.b  = r2;
    case (ins[6:0])
      7'h33: case ({f7, f3})
        {7'h00, 3'd0}: begin e.func = 4'h0; e.value = r1 + r2; end
        {7'h20, 3'd0}: begin e.func = 4'h8; e.value = r1 - r2; end
        {7'h00, 3'd1}: begin e.func = 4'h6; e.b = {27'd0, sh}; e.value = r1 << sh; end
        {7'h00, 3'd2}: begin e.func = 4'h1; e.value = {31'd0, $signed(r1) < $signed(r2)}; end
        {7'h00, 3'd3}: begin e.func = 4'h2; e.value = {31'd0, r1 < r2}; end
        {7'h00, 3'd4}: begin e.func = 4'h5; e.value = r1 ^ r2; end
        {7'h00, 3'd5}: begin e.func = 4'h7; e.b = {27'd0, sh}; e.value = r1 >> sh; end
        {7'h20, 3'd5}: begin e.func = 4'h9; e.b = {27'd0, sh}; e.value = $signed(r1) >>> sh; end
        {7'h00, 3'd6}: begin e.func = 4'h4; e.value = r1 | r2; end
        {7'h00, 3'd7}: begin e.func = 4'h3; e.value = r1 & r2; end
        default: e.ill = 1'b1;
      endcase
      7'h13: begin
        e.b = ii;
        case (f3)
          3'd0: begin e.func = 4'h0; e.value = r1 + ii; end
          3'd2: begin e.func = 4'h1; e.value = {31'd0, $signed(r1) < $signed(ii)}; end
          3'd3: begin e.func = 4'h2; e.value = {31'd0, r1 < ii}; end
          3'd4: begin e.func = 4'h5; e.value = r1 ^ ii; end
          3'd6: begin e.func = 4'h4; e.value = r1 | ii; end
          3'd7: begin e.func = 4'h3; e.value = r1 & ii; end
          3'd1: begin e.ill = f7 != 7'h00; e.func = 4'h6; e.b = {27'd0, si}; e.value = r1 << si; end
          default: begin
            e.ill = f7 != 7'h00 && f7 != 7'h20;
            e.b   = {27'd0, si};
            e.func  = f7 == 7'h20 ? 4'h9 : 4'h7;
            e.value = f7 == 7'h20 ? $signed(r1) >>> si : r1 >> si;
          end
        endcase
      end
      7'h63: begin
        e.br     = 1'b1;
        e.target = pc + bi;
        case (f3)
          3'd0: begin e.func = 4'hA; e.taken = r1 == r2; end
          3'd1: begin e.func = 4'hB; e.taken = r1 != r2; end
          3'd4: begin e.func = 4'h1; e.taken = $signed(r1) < $signed(r2); end
          3'd5: begin e.func = 4'hC; e.taken = $signed(r1) >= $signed(r2); end
          3'd6: begin e.func = 4'h2; e.taken = r1 < r2; end
          3'd7: begin e.func = 4'hD; e.taken = r1 >= r2; end
          default: e.ill = 1'b1;
        endcase
        e.value = {31'd0, e.taken};
      end
      7'h37: begin e.a = 32'd0; e.b = ui; e.value = ui; end
      7'h17: begin e.a = pc; e.b = ui; e.value = pc + ui; end
      default: e.ill = 1'b1;
    endcase
    e.we = !e.ill && !e.br && e.rd != 5'd0;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_alu_enable"}, bus.alu_enable, 0);
    chk({tag, "_alu_func"}, bus.alu_func, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_rd"}, bus.out_rd, 0);
    chk({tag, "_out_we"}, bus.out_we, 0);
    chk({tag, "_out_value"}, bus.out_value, 0);
    chk({tag, "_out_branch"}, bus.out_branch, 0);
    chk({tag, "_out_taken"}, bus.out_taken, 0);
    chk({tag, "_out_target"}, bus.out_target, 0);
    chk({tag, "_out_illegal"}, bus.out_illegal, 0);
  endtask
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2, input int hold);
    exp_t e;
    int cyc, en;
    logic [31:0] v;
    e = ref_model(ins, pc, r1, r2);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.in_rs1_val = r1;
    bus.in_rs2_val = r2;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_instr = $urandom;
    bus.in_pc = $urandom;
    bus.in_rs1_val = $urandom;
    bus.in_rs2_val = $urandom;
    en = 0;
    cyc = 1;
    while (!bus.out_valid && cyc < 8) begin
      if (bus.alu_enable) begin
        en++;
        chk("alu_func", bus.alu_func, e.func);
        chk("alu_a", bus.alu_a, e.a);
        chk("alu_b", bus.alu_b, e.b);
      end
      chk("in_ready_busy", bus.in_ready, 0);
      @(negedge clock);
      cyc++;
    end
    chk("latency", cyc, e.ill ? 1 : 3);
    chk("enable_pulses", en, e.ill ? 0 : 1);
    chk("out_illegal", bus.out_illegal, e.ill);
    chk("out_we", bus.out_we, e.we);
    if (!e.ill) begin
      chk("out_value", bus.out_value, e.value);
      chk("out_branch", bus.out_branch, e.br);
      chk("alu_func_held", bus.alu_func, e.func);
      if (e.br) begin
        chk("out_taken", bus.out_taken, e.taken);
        chk("out_target", bus.out_target, e.target);
      end else chk("out_rd", bus.out_rd, e.rd);
    end
    v = bus.out_value;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_value", bus.out_value, v);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_enable", bus.alu_enable, 0);
    end
    chk("done_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_in_ready", bus.in_ready, 1);
  endtask
  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0] f7;
    int k;
    w = $urandom;
    k = $urandom_range(0, 8);
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case (k)
      0, 1: begin w[6:0] = 7'h33; w[31:25] = f7; end
      2:    w[6:0] = 7'h13;
      3:    begin w[6:0] = 7'h13; w[31:25] = f7; end
      4, 5: w[6:0] = 7'h63;
      6:    w[6:0] = 7'h37;
      7:    w[6:0] = 7'h17;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.in_rs1_val = '0;
    bus.in_rs2_val = '0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_in_ready", bus.in_ready, 1);
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7, 0);
    issue(32'h4020D1B3, 32'h0, 32'h80000000, 32'h21, 1);
    issue(32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'd1, 0);
    issue(32'hFFF00293, 32'h0, 32'h0, 32'h0, 5);
    issue(32'h00000073, 32'h40, 32'd3, 32'd4, 2);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h002081B3;
    bus.in_rs1_val = 32'd5;
    bus.in_rs2_val = 32'd7;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("mid_reset");
    chk("mid_reset_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("dropped_valid", bus.out_valid, 0);
      chk("dropped_in_ready", bus.in_ready, 1);
    end
    for (int n = 0; n < 200; n++) issue(gen_instr(), $urandom, $urandom, $urandom, $urandom_range(0, 3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
